// File: rtl/bsg_nonsynth_manycore_print_stat_tracker.sv
// Pairs print-stat start/end tags into per-tag elapsed-cycle records and queues them for a consumer.
// Define BSG_PRINT_STAT_TRACKER_DISPLAY_EN to log events, records, drops and errors with $display.
module bsg_nonsynth_manycore_print_stat_tracker #(
    parameter int data_width_p     = 32,
    parameter int num_tags_p       = 16,
    parameter int fifo_els_p       = 4,
    parameter int drop_ctr_width_p = 8,
    localparam int tag_width_lp    = (num_tags_p > 1) ? $clog2(num_tags_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        print_stat_v_i,
    input  logic [data_width_p-1:0]     print_stat_tag_i,
    input  logic [data_width_p-1:0]     global_ctr_i,
    output logic                        record_v_o,
    input  logic                        record_ready_i,
    output logic [tag_width_lp-1:0]     record_tag_o,
    output logic [data_width_p-1:0]     record_cycles_o,
    output logic                        kernel_active_o,
    output logic [drop_ctr_width_p-1:0] drop_count_o,
    output logic                        err_double_start_o,
    output logic                        err_unmatched_end_o
);

    localparam int ptr_width_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_width_lp = $clog2(fifo_els_p + 1);

    typedef enum logic [1:0] {
        e_stat   = 2'b00,
        e_start  = 2'b01,
        e_end    = 2'b10,
        e_kernel = 2'b11
    } event_type_e;

    event_type_e              ev_type;
    logic [tag_width_lp-1:0]  ev_id;
    logic                     ev_valid;
    logic                     is_start;
    logic                     is_end;
    logic                     is_kernel;
    logic                     unused_tag_bits;

    logic [num_tags_p-1:0]    open_r;
    logic [data_width_p-1:0]  start_ts_r [num_tags_p];
    logic                     kernel_active_r;
    logic                     err_double_start_r;
    logic                     err_unmatched_end_r;
    logic [drop_ctr_width_p-1:0] drop_count_r;

    logic [tag_width_lp-1:0]  tag_mem [fifo_els_p];
    logic [data_width_p-1:0]  cyc_mem [fifo_els_p];
    logic [ptr_width_lp-1:0]  rd_ptr_r;
    logic [ptr_width_lp-1:0]  wr_ptr_r;
    logic [cnt_width_lp-1:0]  count_r;

    logic                     fifo_full;
    logic                     deq;
    logic                     enq_req;
    logic                     enq;
    logic                     drop;
    logic [data_width_p-1:0]  elapsed;

    assign ev_type   = event_type_e'(print_stat_tag_i[data_width_p-1 -: 2]);
    assign ev_id     = print_stat_tag_i[tag_width_lp-1:0];
    assign ev_valid  = print_stat_v_i & ~reset_i;
    assign is_start  = ev_valid & (ev_type == e_start);
    assign is_end    = ev_valid & (ev_type == e_end);
    assign is_kernel = ev_valid & (ev_type == e_kernel);

    // Only the type field and the ID field carry meaning; the rest is ignored.
    assign unused_tag_bits = ^print_stat_tag_i[data_width_p-3:tag_width_lp];

    // Wrapping subtraction gives the right answer across a counter rollover.
    assign elapsed   = global_ctr_i - start_ts_r[ev_id];

    assign fifo_full = (count_r == cnt_width_lp'(fifo_els_p));
    assign deq       = record_v_o & record_ready_i;
    assign enq_req   = is_end & open_r[ev_id];
    assign enq       = enq_req & (~fifo_full | deq);
    assign drop      = enq_req & fifo_full & ~deq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        if (p == ptr_width_lp'(fifo_els_p - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r            <= '0;
            wr_ptr_r            <= '0;
            count_r             <= '0;
            open_r              <= '0;
            kernel_active_r     <= 1'b0;
            err_double_start_r  <= 1'b0;
            err_unmatched_end_r <= 1'b0;
            drop_count_r        <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (deq) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase

            if (is_kernel) begin
                open_r          <= '0;
                kernel_active_r <= print_stat_tag_i[0];
            end else if (is_start) begin
                open_r[ev_id] <= 1'b1;
                if (open_r[ev_id]) begin
                    err_double_start_r <= 1'b1;
                end
            end else if (is_end) begin
                if (open_r[ev_id]) begin
                    open_r[ev_id] <= 1'b0;
                end else begin
                    err_unmatched_end_r <= 1'b1;
                end
            end

            if (drop && (drop_count_r != '1)) begin
                drop_count_r <= drop_count_r + 1'b1;
            end
        end
    end

    // Storage needs no reset: the count and open bits decide what is meaningful.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            tag_mem[wr_ptr_r] <= ev_id;
            cyc_mem[wr_ptr_r] <= elapsed;
        end
        if (is_start) begin
            start_ts_r[ev_id] <= global_ctr_i;
        end
    end

    assign record_v_o          = (count_r != '0);
    assign record_tag_o        = tag_mem[rd_ptr_r];
    assign record_cycles_o     = cyc_mem[rd_ptr_r];
    assign kernel_active_o     = kernel_active_r;
    assign drop_count_o        = drop_count_r;
    assign err_double_start_o  = err_double_start_r;
    assign err_unmatched_end_o = err_unmatched_end_r;

`ifdef BSG_PRINT_STAT_TRACKER_DISPLAY_EN
    always @(posedge clk_i) begin
        if (ev_valid) begin
            $display("[TRACKER] cycle=%0d type=%s id=%0d", global_ctr_i, ev_type.name(), ev_id);
        end
        if (enq) begin
            $display("[TRACKER] tag=%0d cycles=%0d", ev_id, elapsed);
        end
        if (drop) begin
            $display("[TRACKER] WARNING: record dropped, fifo full (tag=%0d)", ev_id);
        end
        if (is_start && open_r[ev_id]) begin
            $display("[TRACKER] WARNING: double start on tag=%0d", ev_id);
        end
        if (is_end && !open_r[ev_id]) begin
            $display("[TRACKER] WARNING: unmatched end on tag=%0d", ev_id);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_nonsynth_manycore_print_stat_tracker.sv
// Self-checking bench for the print-stat tracker: directed vector table, multi-cycle corner
// sequences, and a randomized run against a queue-based reference model.
module tb_bsg_nonsynth_manycore_print_stat_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        v;
    logic [31:0] tag;
    logic [31:0] ctr;
    logic        ready;
    logic        rec_v;
    logic [3:0]  rec_tag;
    logic [31:0] rec_cyc;
    logic        kact;
    logic [7:0]  drop_cnt;
    logic        err_ds;
    logic        err_un;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bsg_nonsynth_manycore_print_stat_tracker dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .print_stat_v_i      (v),
        .print_stat_tag_i    (tag),
        .global_ctr_i        (ctr),
        .record_v_o          (rec_v),
        .record_ready_i      (ready),
        .record_tag_o        (rec_tag),
        .record_cycles_o     (rec_cyc),
        .kernel_active_o     (kact),
        .drop_count_o        (drop_cnt),
        .err_double_start_o  (err_ds),
        .err_unmatched_end_o (err_un)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic en, input logic [31:0] tg, input logic [31:0] c, input logic rdy);
        v = en; tag = tg; ctr = c; ready = rdy;
        tick();
        v = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] id);
        return {t, 26'd0, id};
    endfunction

    typedef struct {
        logic        v;
        logic [31:0] tag;
        logic [31:0] ctr;
        logic        e_v;
        logic [3:0]  e_tag;
        logic [31:0] e_cyc;
        logic        e_kact;
        logic        e_ds;
        logic        e_un;
    } vec_t;

    vec_t vecs [16];

    // reference model state
    logic        m_open [16];
    logic [31:0] m_ts   [16];
    logic [3:0]  mq_tag [$];
    logic [31:0] mq_cyc [$];
    logic        m_kact, m_ds, m_un;
    int          m_drop;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
        mq_tag.delete(); mq_cyc.delete();
        m_kact = 0; m_ds = 0; m_un = 0; m_drop = 0;
    endtask

    task automatic model_step();
        logic [1:0] t;
        int id;
        if (reset) begin
            model_reset();
            return;
        end
        if (mq_tag.size() > 0 && ready) begin
            void'(mq_tag.pop_front());
            void'(mq_cyc.pop_front());
        end
        if (!v) return;
        t  = tag[31:30];
        id = int'(tag[3:0]);
        case (t)
            2'b01: begin
                if (m_open[id]) m_ds = 1;
                m_open[id] = 1;
                m_ts[id]   = ctr;
            end
            2'b10: begin
                if (m_open[id]) begin
                    m_open[id] = 0;
                    if (mq_tag.size() < 4) begin
                        mq_tag.push_back(tag[3:0]);
                        mq_cyc.push_back(ctr - m_ts[id]);
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end else begin
                    m_un = 1;
                end
            end
            2'b11: begin
                for (int i = 0; i < 16; i++) m_open[i] = 0;
                m_kact = tag[0];
            end
            default: ;
        endcase
    endtask

    task automatic model_compare();
        chk("rnd_rec_v", rec_v, mq_tag.size() > 0);
        if (mq_tag.size() > 0) begin
            chk("rnd_rec_tag", rec_tag, mq_tag[0]);
            chk("rnd_rec_cycles", rec_cyc, mq_cyc[0]);
        end
        chk("rnd_kernel_active", kact, m_kact);
        chk("rnd_drop_count", drop_cnt, m_drop);
        chk("rnd_err_double_start", err_ds, m_ds);
        chk("rnd_err_unmatched_end", err_un, m_un);
    endtask

    initial begin
        int n_drained;
        logic [3:0]  last_tag;
        logic [31:0] last_cyc;
        logic [31:0] r;
        logic [31:0] rctr;
        logic [1:0]  typ;

        vecs[0]  = '{1'b1, 32'h4000_0003, 32'd100,        1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'd200,        1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0003, 32'd250,        1'b1, 4'd3, 32'd150, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'd260,        1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'hC000_0001, 32'd300,        1'b0, 4'd0, 32'd0,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h4000_0007, 32'd305,        1'b0, 4'd0, 32'd0,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'hC000_0000, 32'd310,        1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h8000_0007, 32'd320,        1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 32'h4000_0002, 32'd10,         1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h4000_0002, 32'd40,         1'b0, 4'd0, 32'd0,  1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 32'h8000_0002, 32'd100,        1'b1, 4'd2, 32'd60, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'd110,        1'b0, 4'd0, 32'd0,  1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 32'h7FFF_FFF1, 32'hFFFF_FFF0,  1'b0, 4'd0, 32'd0,  1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_0001, 32'hFFFF_FFF8,  1'b0, 4'd0, 32'd0,  1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 32'h8000_0011, 32'h0000_0010,  1'b1, 4'd1, 32'h20, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 32'h8000_0005, 32'h0000_0020,  1'b0, 4'd0, 32'd0,  1'b0, 1'b1, 1'b1};

        reset = 1'b1; v = 1'b0; tag = '0; ctr = '0; ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("reset_rec_v", rec_v, 0);
        chk("reset_kernel_active", kact, 0);
        chk("reset_drop_count", drop_cnt, 0);
        chk("reset_err_double_start", err_ds, 0);
        chk("reset_err_unmatched_end", err_un, 0);

        for (int i = 0; i < 16; i++) begin
            ev(vecs[i].v, vecs[i].tag, vecs[i].ctr, 1'b1);
            chk($sformatf("vec%0d_rec_v", i), rec_v, vecs[i].e_v);
            if (vecs[i].e_v) begin
                chk($sformatf("vec%0d_rec_tag", i), rec_tag, vecs[i].e_tag);
                chk($sformatf("vec%0d_rec_cycles", i), rec_cyc, vecs[i].e_cyc);
            end
            chk($sformatf("vec%0d_kernel_active", i), kact, vecs[i].e_kact);
            chk($sformatf("vec%0d_err_double_start", i), err_ds, vecs[i].e_ds);
            chk($sformatf("vec%0d_err_unmatched_end", i), err_un, vecs[i].e_un);
            chk($sformatf("vec%0d_drop_count", i), drop_cnt, 0);
        end

        // Backpressure: six pairs into a four-deep FIFO
        for (int i = 0; i < 6; i++) begin
            ev(1'b1, mk(2'b01, 4'(i)), 32'(5000 + 100 * i), 1'b0);
            ev(1'b1, mk(2'b10, 4'(i)), 32'(5000 + 100 * i + 10 + i), 1'b0);
        end
        chk("bp_rec_v", rec_v, 1);
        chk("bp_drop_count", drop_cnt, 2);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_drain%0d_v", k), rec_v, 1);
            chk($sformatf("bp_drain%0d_tag", k), rec_tag, k);
            chk($sformatf("bp_drain%0d_cycles", k), rec_cyc, 10 + k);
            ev(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("bp_empty_after_drain", rec_v, 0);

        // Full FIFO with an end event coinciding with a dequeue
        for (int i = 0; i < 4; i++) begin
            ev(1'b1, mk(2'b01, 4'(i)), 32'd1000, 1'b0);
            ev(1'b1, mk(2'b10, 4'(i)), 32'(1020 + i), 1'b0);
        end
        chk("full_hold_tag", rec_tag, 0);
        ev(1'b1, mk(2'b01, 4'd9), 32'd0, 1'b0);
        ev(1'b1, mk(2'b10, 4'd9), 32'd30, 1'b1);
        chk("full_deq_drop_count", drop_cnt, 2);
        chk("full_deq_head_tag", rec_tag, 1);
        chk("full_deq_head_cycles", rec_cyc, 21);
        n_drained = 0; last_tag = '0; last_cyc = '0;
        for (int k = 0; k < 8; k++) begin
            if (!rec_v) break;
            last_tag = rec_tag; last_cyc = rec_cyc;
            n_drained++;
            ev(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("full_deq_occupancy", n_drained, 4);
        chk("full_deq_last_tag", last_tag, 9);
        chk("full_deq_last_cycles", last_cyc, 30);

        // Reset with records queued, a kernel active and an open region
        ev(1'b1, 32'hC000_0001, 32'd0, 1'b0);
        for (int i = 4; i < 7; i++) begin
            ev(1'b1, mk(2'b01, 4'(i)), 32'd0, 1'b0);
            ev(1'b1, mk(2'b10, 4'(i)), 32'd5, 1'b0);
        end
        ev(1'b1, mk(2'b01, 4'd8), 32'd7, 1'b0);
        chk("pre_reset_kernel_active", kact, 1);
        chk("pre_reset_rec_v", rec_v, 1);
        reset = 1'b1;
        ev(1'b1, mk(2'b10, 4'd8), 32'd9, 1'b0);
        reset = 1'b0;
        chk("mid_reset_rec_v", rec_v, 0);
        chk("mid_reset_kernel_active", kact, 0);
        chk("mid_reset_drop_count", drop_cnt, 0);
        chk("mid_reset_err_double_start", err_ds, 0);
        chk("mid_reset_err_unmatched_end", err_un, 0);
        ev(1'b1, mk(2'b10, 4'd8), 32'd12, 1'b1);
        chk("post_reset_unmatched", err_un, 1);
        chk("post_reset_no_record", rec_v, 0);

        // Randomized run against the reference model
        reset = 1'b1; v = 1'b0;
        model_step();
        tick();
        reset = 1'b0;
        rctr = 32'hFFFF_F000;
        for (int c = 0; c < 3000; c++) begin
            r     = $urandom();
            typ   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) != 0 && typ == 2'b11) typ = 2'b10;
            v     = ($urandom_range(0, 2) != 0);
            tag   = {typ, r[29:4], 4'($urandom_range(0, 3))};
            rctr  = rctr + 32'($urandom_range(1, 60));
            ctr   = rctr;
            ready = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 399) == 0);
            model_step();
            tick();
            model_compare();
        end
        reset = 1'b0; v = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
